// File: rtl/comparator_pkg.sv
// Shared types for the pipelined magnitude comparator.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
//
// cmp_state_t : per-stage resolution state carried down the pipe.
// cmp_flags_t : one-hot {eq, gt, lt} result flags.
// cmp_decode  : state -> one-hot flags.
package comparator_pkg;

  // EQ means "undecided so far"; GT/LT are sticky once set.
  typedef enum logic [1:0] {
    CMP_EQ = 2'b00,
    CMP_GT = 2'b01,
    CMP_LT = 2'b10
  } cmp_state_t;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_flags_t;

  function automatic cmp_flags_t cmp_decode(input cmp_state_t st);
    cmp_flags_t f;
    f = '0;
    case (st)
      CMP_EQ:  f.eq = 1'b1;
      CMP_GT:  f.gt = 1'b1;
      CMP_LT:  f.lt = 1'b1;
      default: f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/comparator_slice.sv
// One slice of the magnitude compare: refines the running state with a SLICE-bit chunk.
// Latency: combinational.
// Backpressure: none; stall handling lives in the enclosing pipeline.
//
// Ports:
//   state_in  : state resolved by all more-significant slices
//   a_slice   : SLICE bits of operand A for this position
//   b_slice   : SLICE bits of operand B for this position
//   state_out : state after considering this slice
module comparator_slice
  import comparator_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  cmp_state_t       state_in,
  input  logic [SLICE-1:0] a_slice,
  input  logic [SLICE-1:0] b_slice,
  output cmp_state_t       state_out
);

  // A decision made by a more-significant slice is final; only an
  // undecided (EQ) state looks at this slice.
  always_comb begin
    state_out = state_in;
    if (state_in == CMP_EQ) begin
      if (a_slice > b_slice) begin
        state_out = CMP_GT;
      end else if (a_slice < b_slice) begin
        state_out = CMP_LT;
      end
    end
  end

endmodule

// File: rtl/comparator_pipe.sv
// Pipelined WIDTH-bit magnitude comparator (signed/unsigned per transaction), MSB slice first.
// Latency: STAGES = WIDTH/SLICE cycles from accept to out_valid; one result per cycle.
// Backpressure: global stall; in_ready = !out_valid || out_ready, whole pipe holds when low.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : input handshake for in_a, in_b, in_signed
//   in_signed             : 1 = two's-complement compare, 0 = unsigned
//   out_valid/out_ready   : output handshake
//   out_eq/out_gt/out_lt  : one-hot relation of A to B
//   out_max/out_min       : larger/smaller operand (A is max, B is min on equality)
module comparator_pipe
  import comparator_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_eq,
  output logic             out_gt,
  output logic             out_lt,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min
);

  // Guarded so a bad SLICE reports the error below instead of dividing by zero.
  localparam int SLICE_SAFE = (SLICE > 0) ? SLICE : 1;
  localparam int STAGES     = WIDTH / SLICE_SAFE;
  // Registered stages between the input and the output register.
  localparam int NREG       = (STAGES > 1) ? STAGES - 1 : 1;

  if (SLICE < 1) begin : g_chk_slice
    $error("comparator_pipe: SLICE must be at least 1");
  end
  if ((WIDTH < SLICE_SAFE) || ((WIDTH % SLICE_SAFE) != 0)) begin : g_chk_width
    $error("comparator_pipe: WIDTH must be a non-zero multiple of SLICE");
  end

  logic advance;

  // Inter-stage registers. Entry k holds the transaction after slice k
  // has been resolved. The signed mode only matters for the MSB slice,
  // which is resolved before the first register, so it is not carried.
  logic [NREG-1:0]  vld_q;
  logic [WIDTH-1:0] a_q  [NREG];
  logic [WIDTH-1:0] b_q  [NREG];
  cmp_state_t       st_q [NREG];

  // Per-stage next state from the slice comparators.
  cmp_state_t       st_nx [STAGES];

  // Operands feeding the output register.
  logic             fin_vld;
  logic [WIDTH-1:0] fin_a;
  logic [WIDTH-1:0] fin_b;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int HI = WIDTH - 1 - k * SLICE_SAFE;

    cmp_state_t            st_src;
    logic [SLICE_SAFE-1:0] sl_a;
    logic [SLICE_SAFE-1:0] sl_b;

    if (k == 0) begin : g_head
      // Signed compare as offset binary: flipping the sign bit maps the
      // two's-complement range onto an order-preserving unsigned range.
      // Only the compare sees the flip; the stored operands are untouched.
      always_comb begin
        sl_a               = in_a[HI -: SLICE_SAFE];
        sl_b               = in_b[HI -: SLICE_SAFE];
        sl_a[SLICE_SAFE-1] = in_a[WIDTH-1] ^ in_signed;
        sl_b[SLICE_SAFE-1] = in_b[WIDTH-1] ^ in_signed;
      end
      assign st_src = CMP_EQ;
    end else begin : g_body
      assign sl_a   = a_q[k-1][HI -: SLICE_SAFE];
      assign sl_b   = b_q[k-1][HI -: SLICE_SAFE];
      assign st_src = st_q[k-1];
    end

    comparator_slice #(
      .SLICE (SLICE_SAFE)
    ) u_slice (
      .state_in  (st_src),
      .a_slice   (sl_a),
      .b_slice   (sl_b),
      .state_out (st_nx[k])
    );
  end

  if (STAGES == 1) begin : g_fin_direct
    assign fin_vld = in_valid;
    assign fin_a   = in_a;
    assign fin_b   = in_b;
  end else begin : g_fin_pipe
    assign fin_vld = vld_q[STAGES-2];
    assign fin_a   = a_q[STAGES-2];
    assign fin_b   = b_q[STAGES-2];
  end

  // Data registers only load behind a valid bit, so garbage on the
  // operand inputs while idle never enters the pipe. Bubbles simply
  // shift through as cleared valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      out_valid <= 1'b0;
      out_eq    <= 1'b0;
      out_gt    <= 1'b0;
      out_lt    <= 1'b0;
      out_max   <= '0;
      out_min   <= '0;
    end else if (advance) begin
      if (STAGES > 1) begin
        vld_q[0] <= in_valid;
        if (in_valid) begin
          a_q[0]  <= in_a;
          b_q[0]  <= in_b;
          st_q[0] <= st_nx[0];
        end
        for (int k = 1; k < STAGES - 1; k++) begin
          vld_q[k] <= vld_q[k-1];
          if (vld_q[k-1]) begin
            a_q[k]  <= a_q[k-1];
            b_q[k]  <= b_q[k-1];
            st_q[k] <= st_nx[k];
          end
        end
      end

      out_valid <= fin_vld;
      if (fin_vld) begin
        {out_eq, out_gt, out_lt} <= cmp_decode(st_nx[STAGES-1]);
        // Equality keeps A as max and B as min.
        out_max <= (st_nx[STAGES-1] == CMP_LT) ? fin_b : fin_a;
        out_min <= (st_nx[STAGES-1] == CMP_LT) ? fin_a : fin_b;
      end
    end
  end

endmodule

// File: tb/tb_comparator_pipe.sv
module tb_comparator_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 32-bit, 4-stage instance
  logic        in_valid, in_ready, in_signed;
  logic        out_valid, out_ready, out_eq, out_gt, out_lt;
  logic [31:0] in_a, in_b, out_max, out_min;

  // 8-bit, single-stage instance
  logic        v8_in_valid, v8_in_ready, v8_in_signed;
  logic        v8_out_valid, v8_out_ready, v8_eq, v8_gt, v8_lt;
  logic [7:0]  v8_a, v8_b, v8_max, v8_min;

  comparator_pipe #(.WIDTH(32), .SLICE(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_eq    (out_eq),
    .out_gt    (out_gt),
    .out_lt    (out_lt),
    .out_max   (out_max),
    .out_min   (out_min)
  );

  comparator_pipe #(.WIDTH(8), .SLICE(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v8_in_valid),
    .in_ready  (v8_in_ready),
    .in_a      (v8_a),
    .in_b      (v8_b),
    .in_signed (v8_in_signed),
    .out_valid (v8_out_valid),
    .out_ready (v8_out_ready),
    .out_eq    (v8_eq),
    .out_gt    (v8_gt),
    .out_lt    (v8_lt),
    .out_max   (v8_max),
    .out_min   (v8_min)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        eq;
    logic        gt;
    logic        lt;
    logic [31:0] mx;
    logic [31:0] mn;
  } res_t;

  res_t exp_q[$];
  bit   sb_on       = 1'b0;
  int   n_rx        = 0;
  int   last_rx_cyc = 0;
  bit   prev_stall  = 1'b0;
  res_t prev_g;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: interpret both operands as w-bit numbers and compare them
  // as plain integers.
  function automatic res_t ref_cmp(input logic [31:0] a, input logic [31:0] b,
                                   input logic sgn, input int w);
    longint va, vb, span;
    res_t   r;
    span = longint'(1) << w;
    va   = longint'(a);
    vb   = longint'(b);
    if (sgn && a[w-1]) va = va - span;
    if (sgn && b[w-1]) vb = vb - span;
    r.eq = (va == vb);
    r.gt = (va > vb);
    r.lt = (va < vb);
    r.mx = r.lt ? b : a;
    r.mn = r.lt ? a : b;
    return r;
  endfunction

  // Scoreboard and stall-stability monitor, sampled on the falling edge.
  always @(negedge clk) begin : mon
    res_t g;
    res_t e;
    g = {out_eq, out_gt, out_lt, out_max, out_min};
    if (sb_on && !rst) begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", g, prev_g);
      end
      if (out_valid && out_ready) begin
        n_rx++;
        last_rx_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_result", g, e);
          chk("sb_onehot", $countones({out_eq, out_gt, out_lt}), 1);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_g     = g;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic e_eq, input logic e_gt, input logic e_lt,
                         input logic [31:0] e_mx, input logic [31:0] e_mn);
    int lat;
    out_ready = 1'b1;
    in_a      = a;
    in_b      = b;
    in_signed = sgn;
    in_valid  = 1'b1;
    #1;
    chk("dir_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_a     = 'x;
    in_b     = 'x;
    lat      = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("dir_latency", lat, 4);
    chk("dir_flags", {out_eq, out_gt, out_lt}, {e_eq, e_gt, e_lt});
    chk("dir_max", out_max, e_mx);
    chk("dir_min", out_min, e_mn);
    tick();
    chk("dir_bubble", out_valid, 0);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                      input logic e_eq, input logic e_gt, input logic e_lt,
                      input logic [7:0] e_mx, input logic [7:0] e_mn);
    int   lat;
    res_t r;
    r            = ref_cmp({24'h0, a}, {24'h0, b}, sgn, 8);
    v8_a         = a;
    v8_b         = b;
    v8_in_signed = sgn;
    v8_in_valid  = 1'b1;
    tick();
    v8_in_valid = 1'b0;
    lat         = 1;
    while (!v8_out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("w8_latency", lat, 1);
    chk("w8_flags", {v8_eq, v8_gt, v8_lt}, {e_eq, e_gt, e_lt});
    chk("w8_max", v8_max, e_mx);
    chk("w8_min", v8_min, e_mn);
    chk("w8_model", {v8_eq, v8_gt, v8_lt, v8_max, v8_min},
        {r.eq, r.gt, r.lt, r.mx[7:0], r.mn[7:0]});
    tick();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          t0, sent, acc, any, stall_left;
    bit          pending, seen_valid;
    logic [31:0] pa, pb;
    logic        ps;

    rst          = 1'b1;
    in_valid     = 1'b0;
    in_a         = '0;
    in_b         = '0;
    in_signed    = 1'b0;
    out_ready    = 1'b0;
    v8_in_valid  = 1'b0;
    v8_a         = '0;
    v8_b         = '0;
    v8_in_signed = 1'b0;
    v8_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state (out_ready low so in_ready must come from !out_valid)
    chk("rst_out_valid", out_valid, 0);
    chk("rst_flags", {out_eq, out_gt, out_lt}, 3'b000);
    chk("rst_max", out_max, 0);
    chk("rst_min", out_min, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_w8_valid", v8_out_valid, 0);

    // Directed 32-bit cases
    run_one(32'h12345678, 32'h12345678, 1'b0, 1, 0, 0, 32'h12345678, 32'h12345678);
    run_one(32'hFFFFFFFF, 32'h00000001, 1'b1, 0, 0, 1, 32'h00000001, 32'hFFFFFFFF);
    run_one(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1, 0, 32'hFFFFFFFF, 32'h00000001);
    run_one(32'hAABBCC10, 32'hAABBCC0F, 1'b0, 0, 1, 0, 32'hAABBCC10, 32'hAABBCC0F);
    run_one(32'h01000000, 32'h00FFFFFF, 1'b0, 0, 1, 0, 32'h01000000, 32'h00FFFFFF);
    run_one(32'h80000000, 32'h7FFFFFFF, 1'b1, 0, 0, 1, 32'h7FFFFFFF, 32'h80000000);

    // Single-stage instance
    run8(8'hA0, 8'h60, 1'b0, 0, 1, 0, 8'hA0, 8'h60);
    run8(8'h11, 8'h22, 1'b0, 0, 0, 1, 8'h22, 8'h11);
    run8(8'h55, 8'h55, 1'b0, 1, 0, 0, 8'h55, 8'h55);
    run8(8'hA0, 8'h60, 1'b1, 0, 0, 1, 8'h60, 8'hA0);

    // Back-to-back stream: full throughput, no bubbles
    exp_q.delete();
    n_rx      = 0;
    sb_on     = 1'b1;
    out_ready = 1'b1;
    t0        = cyc;
    for (int i = 0; i < 8; i++) begin
      in_a      = $urandom;
      in_b      = (i % 3 == 0) ? in_a : $urandom;
      in_signed = $urandom_range(0, 1);
      in_valid  = 1'b1;
      #1;
      chk("tput_in_ready", in_ready, 1);
      exp_q.push_back(ref_cmp(in_a, in_b, in_signed, 32));
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 20 && n_rx < 8; c++) tick();
    chk("tput_count", n_rx, 8);
    chk("tput_span", last_rx_cyc - t0, 11);

    // Backpressure: 6 back-to-back, 3-cycle stall once out_valid rises
    exp_q.delete();
    n_rx       = 0;
    sent       = 0;
    stall_left = 3;
    seen_valid = 1'b0;
    pending    = 1'b0;
    for (int c = 0; c < 80 && n_rx < 6; c++) begin
      if (out_valid) seen_valid = 1'b1;
      if (seen_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      if (!pending && sent < 6) begin
        pa      = $urandom;
        pb      = $urandom_range(0, 1) ? pa ^ (32'h1 << $urandom_range(0, 31)) : $urandom;
        ps      = $urandom_range(0, 1);
        pending = 1'b1;
      end
      in_valid  = pending;
      in_a      = pa;
      in_b      = pb;
      in_signed = ps;
      #1;
      if (!out_ready) chk("bp_in_ready_low", in_ready, 0);
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_cmp(pa, pb, ps, 32));
        sent++;
        pending = 1'b0;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_sent", sent, 6);
    chk("bp_count", n_rx, 6);
    chk("bp_leftover", exp_q.size(), 0);
    chk("bp_stall_done", stall_left, 0);

    // Reset mid-flight
    sb_on = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      in_a      = $urandom;
      in_b      = $urandom;
      in_signed = 1'b0;
      in_valid  = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_flags", {out_eq, out_gt, out_lt}, 3'b000);
    chk("midrst_max", out_max, 0);
    chk("midrst_min", out_min, 0);
    any = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) any = 1;
      tick();
    end
    chk("midrst_no_partial", any, 0);
    run_one(32'h00000005, 32'h00000009, 1'b0, 0, 0, 1, 32'h00000009, 32'h00000005);

    // Randomized traffic with random backpressure and idle garbage
    exp_q.delete();
    n_rx    = 0;
    acc     = 0;
    pending = 1'b0;
    sb_on   = 1'b1;
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!pending && $urandom_range(0, 2) != 0) begin
        pa = $urandom;
        case ($urandom_range(0, 3))
          0:       pb = pa;
          1:       pb = pa ^ (32'h1 << $urandom_range(0, 31));
          2:       pb = ~pa;
          default: pb = $urandom;
        endcase
        ps      = $urandom_range(0, 1);
        pending = 1'b1;
      end
      in_valid  = pending;
      in_a      = pending ? pa : 'x;
      in_b      = pending ? pb : 'x;
      in_signed = ps;
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_cmp(pa, pb, ps, 32));
        acc++;
        pending = 1'b0;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) tick();
    chk("rand_drain", exp_q.size(), 0);
    chk("rand_count", n_rx, acc);
    sb_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
